// File: rtl/multichannel_slew_limiter_if.sv
// Sample/strobe bundle for the multichannel slew limiter.
// The master drives the strobe and samples; the slave returns the limited outputs and status.
interface multichannel_slew_limiter_if #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 16
);
    logic                           audio_clk_en;
    logic [CHANNELS*DATA_WIDTH-1:0] in;
    logic [CHANNELS*DATA_WIDTH-1:0] out;
    logic                           out_valid;
    logic                           busy;
    logic                           overrun;
    logic [CHANNELS-1:0]            limiting;

    modport master (
        output audio_clk_en, in,
        input  out, out_valid, busy, overrun, limiting
    );

    modport slave (
        input  audio_clk_en, in,
        output out, out_valid, busy, overrun, limiting
    );
endinterface

// File: rtl/multichannel_slew_limiter.sv
// Time-multiplexed per-channel rise/fall slew limiter, one channel per clk.
// Optional per-channel clamp status: define SLEW_LIMIT_STATUS_EN.
module multichannel_slew_limiter #(
    parameter int  CHANNELS              = 4,
    parameter int  DATA_WIDTH            = 16,
    parameter int  SIGNAL_FRACTION_WIDTH = 14,
    parameter real VCC                   = 12.0,
    parameter real SAMPLE_RATE           = 48000.0,
    parameter real RISE_RATE             = 1000.0,
    parameter real FALL_RATE             = 1000.0
) (
    input logic                        clk,
    input logic                        I_RSTn,
    multichannel_slew_limiter_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam real SCALE =
        real'(64'(1) << SIGNAL_FRACTION_WIDTH) / (VCC * SAMPLE_RATE);
    localparam int MAX_RISE = $rtoi(SCALE * RISE_RATE);
    localparam int MAX_FALL = $rtoi(SCALE * FALL_RATE);
    localparam int LIM      = 1 << (DW - 1);
    localparam int IW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);
    localparam logic signed [DW:0] RISE_K = (DW + 1)'(MAX_RISE);
    localparam logic signed [DW:0] FALL_K = (DW + 1)'(MAX_FALL);

    if (MAX_RISE < 1 || MAX_RISE >= LIM) begin : g_bad_rise
        $error("MAX_RISE out of range");
    end
    if (MAX_FALL < 1 || MAX_FALL >= LIM) begin : g_bad_fall
        $error("MAX_FALL out of range");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         ch_q;
    logic signed [DW-1:0]  snap_q [CHANNELS];
    logic signed [DW-1:0]  work_q [CHANNELS];
    logic [CHANNELS*DW-1:0] out_q;
    logic                  valid_q, busy_q, overrun_q;

    logic signed [DW-1:0]  cur_s, cur_w, nxt;
    logic signed [DW:0]    diff;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.audio_clk_en) state_d = RUN;
            RUN:     if (ch_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result always lies between old value and target, so no saturation.
    always_comb begin
        cur_s = snap_q[ch_q];
        cur_w = work_q[ch_q];
        diff  = {cur_s[DW-1], cur_s} - {cur_w[DW-1], cur_w};
        nxt   = cur_s;
        if (diff > RISE_K)
            nxt = cur_w + RISE_K[DW-1:0];
        else if (diff < -FALL_K)
            nxt = cur_w - FALL_K[DW-1:0];
    end

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                snap_q[k] <= '0;
                work_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            valid_q <= 1'b0;
            if (bus.audio_clk_en && state_q != IDLE)
                overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (bus.audio_clk_en) begin
                        for (int k = 0; k < CHANNELS; k++)
                            snap_q[k] <= bus.in[k*DW +: DW];
                        ch_q   <= '0;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    work_q[ch_q] <= nxt;
                    ch_q         <= ch_q + 1'b1;
                end
                DONE: begin
                    for (int k = 0; k < CHANNELS; k++)
                        out_q[k*DW +: DW] <= work_q[k];
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SLEW_LIMIT_STATUS_EN
    logic [CHANNELS-1:0] lim_work_q, lim_q;
    logic                clamp;

    assign clamp = (diff > RISE_K) || (diff < -FALL_K);

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            lim_work_q <= '0;
            lim_q      <= '0;
        end else if (state_q == RUN) begin
            lim_work_q[ch_q] <= clamp;
        end else if (state_q == DONE) begin
            lim_q <= lim_work_q;
        end
    end

    assign bus.limiting = lim_q;
`else
    assign bus.limiting = '0;
`endif

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_multichannel_slew_limiter.sv
// Randomized bench for multichannel_slew_limiter against a frame-level model.
// Two instances: symmetric defaults and FALL_RATE=2000 (MAX_FALL=56).
module tb_multichannel_slew_limiter;
    localparam int CH = 4;
    localparam int DW = 16;
    localparam int W  = CH * DW;

    logic clk = 1'b0;
    logic I_RSTn;
    always #5 clk = ~clk;

    multichannel_slew_limiter_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) ifa ();
    multichannel_slew_limiter_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) ifb ();

    multichannel_slew_limiter dut_a (
        .clk    (clk),
        .I_RSTn (I_RSTn),
        .bus    (ifa)
    );

    multichannel_slew_limiter #(.FALL_RATE(2000.0)) dut_b (
        .clk    (clk),
        .I_RSTn (I_RSTn),
        .bus    (ifb)
    );

    logic         en;
    logic [W-1:0] in_v;
    assign ifa.audio_clk_en = en;
    assign ifb.audio_clk_en = en;
    assign ifa.in = in_v;
    assign ifb.in = in_v;

    logic [W-1:0]  out_w   [2];
    logic [CH-1:0] lim_w   [2];
    logic          valid_w [2];
    logic          busy_w  [2];
    logic          ovr_w   [2];
    assign out_w[0] = ifa.out;
    assign out_w[1] = ifb.out;
    assign lim_w[0] = ifa.limiting;
    assign lim_w[1] = ifb.limiting;
    assign valid_w[0] = ifa.out_valid;
    assign valid_w[1] = ifb.out_valid;
    assign busy_w[0] = ifa.busy;
    assign busy_w[1] = ifb.busy;
    assign ovr_w[0] = ifa.overrun;
    assign ovr_w[1] = ifb.overrun;

    int n_vec = 0;
    int n_err = 0;
    int cur [2][CH];
    bit lim [2][CH];
    int rise [2] = '{28, 28};
    int fall [2] = '{28, 56};

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk4(int c0, int c1, int c2, int c3);
        logic [W-1:0] v;
        v[0*DW +: DW] = DW'(c0);
        v[1*DW +: DW] = DW'(c1);
        v[2*DW +: DW] = DW'(c2);
        v[3*DW +: DW] = DW'(c3);
        return v;
    endfunction

    function automatic logic [W-1:0] pack(int d);
        return mk4(cur[d][0], cur[d][1], cur[d][2], cur[d][3]);
    endfunction

    function automatic logic [CH-1:0] lim_exp(int d);
        logic [CH-1:0] l = '0;
`ifdef SLEW_LIMIT_STATUS_EN
        for (int k = 0; k < CH; k++) l[k] = lim[d][k];
`endif
        return l;
    endfunction

    function automatic void model_clear();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < CH; k++) begin
                cur[d][k] = 0;
                lim[d][k] = 0;
            end
    endfunction

    // Each channel moves toward its target by at most the rise/fall step.
    function automatic void model_frame(logic [W-1:0] v);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < CH; k++) begin
                int tgt = int'($signed(v[k*DW +: DW]));
                int dl  = tgt - cur[d][k];
                lim[d][k] = 1'b1;
                if (dl > rise[d]) cur[d][k] += rise[d];
                else if (dl < -fall[d]) cur[d][k] -= fall[d];
                else begin
                    cur[d][k] = tgt;
                    lim[d][k] = 1'b0;
                end
            end
    endfunction

    function automatic logic [3:0] flags();
        return {busy_w[1], busy_w[0], valid_w[1], valid_w[0]};
    endfunction

    task automatic check_outs(string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s out%0d", tag, d), out_w[d], pack(d));
            check($sformatf("%s lim%0d", tag, d), lim_w[d], lim_exp(d));
        end
    endtask

    task automatic run_frame(logic [W-1:0] v, string tag);
        @(negedge clk);
        in_v = v;
        en   = 1'b1;
        @(posedge clk);
        #1;
        en   = 1'b0;
        in_v = W'({$urandom, $urandom});
        model_frame(v);
        check({tag, " edge0"}, flags(), 4'b1100);
        for (int i = 1; i <= CH; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s edge%0d", tag, i), flags(), 4'b1100);
        end
        @(posedge clk);
        #1;
        check({tag, " done"}, flags(), 4'b0011);
        check_outs(tag);
        @(posedge clk);
        #1;
        check({tag, " after"}, flags(), 4'b0000);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        I_RSTn = 1'b0;
        model_clear();
        @(negedge clk);
        I_RSTn = 1'b1;
    endtask

    initial begin
        logic [W-1:0] v;
        int b;
        en = 1'b0;
        in_v = mk4(1000, 1000, 1000, 1000);
        I_RSTn = 1'b1;
        model_clear();
        #1 I_RSTn = 1'b0;

        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst out", {out_w[1], out_w[0]} != '0, 1'b0);
            check("rst flags", {flags(), ovr_w[1], ovr_w[0]}, 6'b0);
        end
        @(negedge clk);
        I_RSTn = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("idle out", {out_w[1], out_w[0]} != '0, 1'b0);
            check("idle flags", {flags(), ovr_w[1], ovr_w[0]}, 6'b0);
        end

        v = mk4(1000, 0, 0, 0);
        for (int f = 1; f <= 40; f++) begin
            run_frame(v, $sformatf("rise%0d", f));
            if (f == 35) check("rise35 ch0", 64'(out_w[0][15:0]), 64'd980);
            if (f == 36) check("rise36 ch0", 64'(out_w[0][15:0]), 64'd1000);
        end

        v = mk4(0, 0, 0, 0);
        for (int f = 1; f <= 40; f++) begin
            run_frame(v, $sformatf("fall%0d", f));
            if (f == 17) check("fall17 ch0", 64'(out_w[1][15:0]), 64'd48);
            if (f == 18) check("fall18 ch0", 64'(out_w[1][15:0]), 64'd0);
        end

        b = cur[0][0];
        run_frame(mk4(b + 28, 0, 0, 0), "thr+28");
        check("thr+28 ch0", 64'(out_w[0][15:0]), 64'(16'(b + 28)));
        b = cur[0][0];
        run_frame(mk4(b + 29, 0, 0, 0), "thr+29");
        check("thr+29 ch0", 64'(out_w[0][15:0]), 64'(16'(b + 28)));
        b = cur[0][0];
        run_frame(mk4(b - 29, 0, 0, 0), "thr-29");
        check("thr-29 ch0", 64'(out_w[0][15:0]), 64'(16'(b - 28)));

        pulse_reset();
        v = mk4(0, -16384, 20, 32767);
        run_frame(v, "ind1");
        check("ind1 ch1", 64'(out_w[0][31:16]), 64'(16'hFFE4));
        check("ind1 ch2", 64'(out_w[0][47:32]), 64'd20);
        check("ind1 ch3", 64'(out_w[0][63:48]), 64'd28);
        check("ind1 ch0", 64'(out_w[0][15:0]), 64'd0);
        run_frame(v, "ind2");
        check("ind2 ch1", 64'(out_w[0][31:16]), 64'(16'hFFC8));

        for (int f = 0; f < 60; f++) begin
            int c [CH];
            for (int k = 0; k < CH; k++) begin
                if ($urandom_range(0, 3) == 0)
                    c[k] = int'($signed(16'($urandom)));
                else begin
                    c[k] = cur[0][k] + int'($urandom_range(0, 80)) - 40;
                    if (c[k] > 32767) c[k] = 32767;
                    if (c[k] < -32768) c[k] = -32768;
                end
            end
            run_frame(mk4(c[0], c[1], c[2], c[3]), $sformatf("rnd%0d", f));
        end

        check("ovr before", {ovr_w[1], ovr_w[0]}, 2'b00);
        v = mk4(500, -500, 7, -7);
        @(negedge clk);
        in_v = v;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        model_frame(v);
        @(posedge clk);
        @(negedge clk);
        en = 1'b1;
        in_v = mk4(-3000, 3000, 0, 0);
        @(posedge clk);
        #1;
        en = 1'b0;
        check("ovr edge2", flags(), 4'b1100);
        repeat (2) @(posedge clk);
        #1;
        check("ovr edge4", flags(), 4'b1100);
        @(posedge clk);
        #1;
        check("ovr done", flags(), 4'b0011);
        check_outs("ovr");
        repeat (8) begin
            @(posedge clk);
            #1;
            check("ovr quiet", flags(), 4'b0000);
        end
        check("ovr set", {ovr_w[1], ovr_w[0]}, 2'b11);
        run_frame(mk4(1, 2, 3, 4), "ovr next");
        check("ovr sticky", {ovr_w[1], ovr_w[0]}, 2'b11);

        @(negedge clk);
        in_v = mk4(9000, 9000, 9000, 9000);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        I_RSTn = 1'b0;
        model_clear();
        #1;
        check("midrst out", {out_w[1], out_w[0]} != '0, 1'b0);
        check("midrst flags", {flags(), ovr_w[1], ovr_w[0]}, 6'b0);
        @(negedge clk);
        I_RSTn = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            check("midrst quiet", flags(), 4'b0000);
        end
        check_outs("midrst");
        run_frame(mk4(100, -100, 0, 30), "post rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multichannel_slew_limiter.md
Name: multichannel_slew_limiter

Overview:
- Time-multiplexed, per-channel rate-of-change limiter for the discrete audio chain.
- Separate rise and fall slew limits, set at elaboration.
- Processes CHANNELS signals using one shared compare/add datapath, one channel per clk cycle.
- Triggered once per audio sample by audio_clk_en. All outputs update together in a single cycle with an out_valid strobe.
- Sits between the discrete-circuit stages and the mixer, where several voices each need slew limiting.

Parameters:
- CHANNELS, 4: number of independent channels (1..16).
- DATA_WIDTH, 16: signed sample width per channel.
- SIGNAL_FRACTION_WIDTH, 14: VCC corresponds to 2^SIGNAL_FRACTION_WIDTH.
- VCC, 12.0: supply voltage [V], real.
- SAMPLE_RATE, 48000.0: audio_clk_en rate [Hz], real.
- RISE_RATE, 1000.0: maximum positive slope [V/s], real.
- FALL_RATE, 1000.0: maximum negative slope [V/s], real.

Ports:
- clk  in  1  system clock.
- I_RSTn  in  1  asynchronous, active-low reset.
- audio_clk_en  in  1  one-cycle sample strobe.
- in  in  CHANNELS*DATA_WIDTH  signed inputs; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out  out  CHANNELS*DATA_WIDTH  signed limited outputs, same packing as in.
- out_valid  out  1  one-cycle pulse when out is updated.
- busy  out  1  high while a frame is in progress.
- overrun  out  1  sticky; audio_clk_en arrived while busy.
- limiting  out  CHANNELS  per-channel clamp status (optional feature).

Behaviour:
- Reset is I_RSTn, asynchronous, active-low; clock is clk. While reset is asserted:
  - out, out_valid, busy, overrun, limiting and all working registers are 0.
  - State is IDLE.
  - Reset asserted mid-frame aborts the frame immediately; no partial out update occurs.
- Derived constants, computed in real arithmetic and truncated toward zero:
  - MAX_RISE = int(2^SIGNAL_FRACTION_WIDTH * RISE_RATE / (VCC * SAMPLE_RATE)).
  - MAX_FALL = the same expression using FALL_RATE.
  - With the defaults, both equal 28.
  - Elaboration fails ($error) if either is below 1 or at or above 2^(DATA_WIDTH-1).
- State machine IDLE -> RUN -> DONE -> IDLE:
  - IDLE: on audio_clk_en, latch all CHANNELS inputs into a snapshot, set ch_idx=0, busy=1, go to RUN. This is edge 0.
  - RUN: each cycle, process channel ch_idx against working[ch_idx], then increment ch_idx. After channel CHANNELS-1, go to DONE. Channel k is processed at edge k+1.
  - DONE (edge CHANNELS+1): out <= working (all channels atomically), out_valid=1 for exactly this cycle, busy=0, go to IDLE.
- Latency: out is updated CHANNELS+1 clk edges after the edge that sampled audio_clk_en. A new audio_clk_en is accepted on the cycle after DONE.
- Per-channel arithmetic:
  - diff = snapshot - working, computed at DATA_WIDTH+1 bits signed.
  - diff > MAX_RISE: working + MAX_RISE.
  - diff < -MAX_FALL: working - MAX_FALL.
  - Otherwise: working takes the snapshot value exactly.
  - The result always lies between the old value and the input, so no overflow or saturation logic is needed.
- Inputs are sampled only at the IDLE acceptance edge. Changes to in during a frame have no effect on that frame.
- audio_clk_en while busy (RUN or DONE):
  - The strobe is ignored and the frame continues unchanged.
  - overrun is set to 1 and stays 1 until reset.
- Channels are fully independent; processing order never affects results.

Optional Feature:
- Macro: SLEW_LIMIT_STATUS_EN.
- Defined:
  - limiting[k] is 1 if channel k was clamped (rise or fall) in the last completed frame, else 0.
  - It updates at the DONE edge together with out.
- Undefined:
  - limiting is tied to 0 and no status registers are built.
  - All other behaviour is identical.

Test Plan:
- Reset / idle:
  - Stimulus: assert I_RSTn=0 with in=all 1000, then release with no audio_clk_en.
  - Required: out=0, out_valid=0, busy=0, overrun=0 throughout.
- Rise step and latency (CHANNELS=4, defaults):
  - Stimulus: ch0 in=1000; pulse audio_clk_en once per 100 cycles.
  - Required: busy high on edges 1..4; out_valid on edge 5 only.
  - Required: ch0 outputs 28, 56, …, 980 at frame 35, then exactly 1000 at frame 36 and held.
  - Required: limiting[0]=1 for frames 1..35 and 0 from frame 36 (with the macro defined).
- Asymmetric fall (FALL_RATE=2000.0, so MAX_FALL=56):
  - Stimulus: from out0=1000, set in0=0.
  - Required: 944, 888, …, 48 at frame 17, then 0 at frame 18.
  - Required: the rise path still steps by 28.
- Threshold exactness:
  - in0=out0+28 -> out0=in0 exactly.
  - in0=out0+29 -> out0+28.
  - in0=out0-29 -> out0-28.
- Independence and negatives:
  - Stimulus: ch1 in=-16384, ch2 in=20, ch3 in=32767, all starting from 0.
  - Required: ch1 reads -28 then -56; ch2 reads 20 after one frame; ch3 reads 28.
  - Required: ch0 is unaffected.
- Overrun and reset mid-frame:
  - Second audio_clk_en 2 cycles after the first -> the frame still completes on edge 5 with one update, and overrun=1 stays set.
  - I_RSTn pulsed low on edge 2 of a frame -> out=0, busy=0, no out_valid.
